// File: rtl/sstv_line_capture.sv
// sstv_line_capture: finds the 1200 Hz horizontal sync in the tone stream and times out
// pixel slots along each scanline. Each slot's greyscale colour is queued as
// {pixel index, colour} in a small output FIFO with a valid/ready handshake.
// Build option: define SSTV_LINE_CAPTURE_AVG_EN to push the mean of 8 colour samples
// around the slot centre instead of a single centre sample.
`timescale 1ns / 1ps

module sstv_line_capture #(
  parameter int unsigned PIXELS_PER_LINE = 320,  // <= 512
  parameter int unsigned PIXEL_TICKS     = 46,   // >= 8
  parameter int unsigned SYNC_TICKS_MIN  = 400,
  parameter int unsigned PORCH_TICKS     = 57,
  parameter int unsigned FIFO_DEPTH      = 4     // power of two, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] freq,
  input  logic [1:0]  color,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [1:0]  pix_data,
  output logic [8:0]  pix_x,
  output logic        line_start,
  output logic        line_done,
  output logic        line_err,
  output logic        overflow
);

  localparam int unsigned SyncW  = $clog2(SYNC_TICKS_MIN + 1);
  localparam int unsigned PorchW = $clog2(PORCH_TICKS + 1);
  localparam int unsigned TickW  = $clog2(PIXEL_TICKS);
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [SyncW-1:0]  SyncMax     = SyncW'(SYNC_TICKS_MIN);
  localparam logic [SyncW-1:0]  SyncLast    = SyncW'(SYNC_TICKS_MIN - 1);
  localparam logic [PorchW-1:0] PorchLast   = PorchW'(PORCH_TICKS - 1);
  localparam logic [TickW-1:0]  TickLast    = TickW'(PIXEL_TICKS - 1);
  localparam logic [TickW-1:0]  TickPreLast = TickW'(PIXEL_TICKS - 2);
  localparam logic [8:0]        PixLast     = 9'(PIXELS_PER_LINE - 1);
  localparam logic [CntW-1:0]   CntFull     = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSync, StPorch, StActive} state_e;

  state_e            state_q;
  logic [SyncW-1:0]  sync_cnt_q;
  logic [PorchW-1:0] porch_cnt_q;
  logic [TickW-1:0]  tick_q;
  logic [8:0]        pixel_q;

  logic        in_sync;
  logic        sync_hit;
  logic        push;
  logic [1:0]  push_color;
  logic [10:0] push_entry;

  assign in_sync  = (freq > 12'd1100) && (freq <= 12'd1300);
  // True on the cycle that completes (or extends) a qualifying run of in-window cycles
  assign sync_hit = in_sync && (sync_cnt_q >= SyncLast);

`ifdef SSTV_LINE_CAPTURE_AVG_EN
  localparam logic [TickW-1:0] AvgFirst = TickW'(PIXEL_TICKS / 2 - 4);
  localparam logic [TickW-1:0] AvgLast  = TickW'(PIXEL_TICKS / 2 + 3);

  logic [4:0] avg_sum_q, avg_sum_d, avg_total;

  // Accumulate colour over the 8-cycle window; the last cycle's colour joins combinationally
  always_comb begin
    avg_sum_d = avg_sum_q;
    avg_total = avg_sum_q + {3'b000, color};
    if (state_q == StActive && tick_q == AvgFirst) begin
      avg_sum_d = {3'b000, color};
    end else if (state_q == StActive && tick_q > AvgFirst && tick_q < AvgLast) begin
      avg_sum_d = avg_total;
    end
  end

  // Averaging accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) avg_sum_q <= '0;
    else       avg_sum_q <= avg_sum_d;
  end

  assign push       = (state_q == StActive) && (tick_q == AvgLast);
  assign push_color = 2'(avg_total >> 3);
`else
  localparam logic [TickW-1:0] TickMid = TickW'(PIXEL_TICKS / 2);

  assign push       = (state_q == StActive) && (tick_q == TickMid);
  assign push_color = color;
`endif

  assign push_entry = {pixel_q, push_color};

  // Line FSM, sync/porch/slot counters and registered line pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sync_cnt_q  <= '0;
      porch_cnt_q <= '0;
      tick_q      <= '0;
      pixel_q     <= '0;
      line_start  <= 1'b0;
      line_done   <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      if (!in_sync) begin
        sync_cnt_q <= '0;
      end else if (sync_cnt_q != SyncMax) begin
        sync_cnt_q <= sync_cnt_q + SyncW'(1);
      end
      line_start <= 1'b0;
      line_done  <= 1'b0;
      line_err   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sync_hit) state_q <= StSync;
        end
        StSync: begin
          if (!in_sync) begin
            state_q     <= StPorch;
            porch_cnt_q <= '0;
          end
        end
        StPorch: begin
          if (porch_cnt_q == PorchLast) begin
            state_q    <= StActive;
            line_start <= 1'b1;
            tick_q     <= '0;
            pixel_q    <= '0;
          end else begin
            porch_cnt_q <= porch_cnt_q + PorchW'(1);
          end
        end
        StActive: begin
          if (sync_hit) begin
            line_err <= 1'b1;
            state_q  <= StSync;
            tick_q   <= '0;
            pixel_q  <= '0;
          end else if (tick_q == TickLast) begin
            tick_q <= '0;
            if (pixel_q == PixLast) begin
              state_q <= StIdle;
              pixel_q <= '0;
            end else begin
              pixel_q <= pixel_q + 9'd1;
            end
          end else begin
            tick_q <= tick_q + TickW'(1);
            // Raised one cycle early so the registered pulse lines up with the final tick
            if (tick_q == TickPreLast && pixel_q == PixLast) line_done <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO: storage plus a registered head so pix_* come straight from flops
  logic [10:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [10:0]     head_d;
  logic            pop, full, push_ok;

  assign pop     = pix_valid && pix_ready;
  assign full    = (count_q == CntFull);
  assign push_ok = push && (!full || pop);

  // Next pointers/count and the entry that will sit at the head next cycle
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // The slot being written becomes the head only when nothing older remains
    head_d = (push_ok && wr_ptr_q == rd_ptr_d) ? push_entry : mem_q[rd_ptr_d];
  end

  // FIFO storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  // FIFO control, registered head outputs and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= 2'd0;
      pix_x     <= 9'd0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pix_valid <= (count_d != '0);
      if (count_d != '0) {pix_x, pix_data} <= head_d;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sstv_line_capture.sv
// Directed bench for sstv_line_capture with a scoreboard of expected FIFO entries.
// Honours SSTV_LINE_CAPTURE_AVG_EN when the build defines it.
`timescale 1ns / 1ps

module tb_sstv_line_capture;

`ifdef SSTV_LINE_CAPTURE_AVG_EN
  localparam int Samp = 26;  // push tick in averaging mode
`else
  localparam int Samp = 23;  // push tick in single-sample mode
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] freq;
  logic [1:0]  color;
  logic        pix_ready;
  logic        pix_valid;
  logic [1:0]  pix_data;
  logic [8:0]  pix_x;
  logic        line_start, line_done, line_err, overflow;

  sstv_line_capture #(
    .PIXELS_PER_LINE(320),
    .PIXEL_TICKS    (46),
    .SYNC_TICKS_MIN (400),
    .PORCH_TICKS    (57),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .freq      (freq),
    .color     (color),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .line_start(line_start),
    .line_done (line_done),
    .line_err  (line_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_pop = 0;
  int t_start = 0, t_done = 0, t_err = 0, t_first_pop = 0;
  int t_first, t_x, n_s0, n_d0;
  int mix_exp;
  logic [10:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: pulse bookkeeping and scoreboard pops, sampled mid-cycle
  always @(negedge clk) begin
    logic [10:0] e;
    if (!reset) begin
      if (line_start) begin n_start++; t_start = cyc; end
      if (line_done)  begin n_done++;  t_done  = cyc; end
      if (line_err)   begin n_err++;   t_err   = cyc; end
      if (pix_valid && pix_ready) begin
        if (n_pop == 0) t_first_pop = cyc;
        n_pop++;
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL pop_unexpected: observed pix_x %0d, expected no entry", pix_x);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pop_pix_x", pix_x, e[10:2]);
          check("pop_pix_data", pix_data, e[1:0]);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] col_of(input int f);
    if (f < 1700)      return 2'd0;
    else if (f < 1900) return 2'd1;
    else if (f < 2100) return 2'd2;
    else               return 2'd3;
  endfunction

  task automatic set_tone(input int f);
    freq  = 12'(f);
    color = col_of(f);
  endtask

  // 400 in-window cycles then the first 2200 Hz cycle; t_first marks that cycle
  task automatic do_sync();
    set_tone(1200);
    cycles(400);
    set_tone(2200);
    t_first = cyc;
  endtask

  task automatic wait_done(input int bound);
    int n0 = n_done;
    for (int k = 0; k < bound && n_done == n0; k++) cycles(1);
    check("line_done_seen", n_done - n0, 1);
  endtask

  initial begin
    reset = 1'b1;
    pix_ready = 1'b0;
    set_tone(0);
    cycles(2);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_line_start", line_start, 0);
    check("rst_line_done", line_done, 0);
    check("rst_line_err", line_err, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    cycles(2);

    // Short sync: one cycle short of qualifying
    set_tone(1200);
    cycles(399);
    set_tone(1500);
    cycles(60);
    check("short_no_start", n_start, 0);
    check("short_no_valid", pix_valid, 0);

    // Normal line with the consumer always ready
    pix_ready = 1'b1;
    n_pop = 0;
    n_s0 = n_start;
    for (int x = 0; x < 320; x++) sb.push_back({9'(x), 2'd3});
    do_sync();
    wait_done(16000);
    check("normal_start_count", n_start - n_s0, 1);
    check("normal_start_lat", t_start - t_first, 58);
    check("normal_done_lat", t_done - t_start, 14719);
    check("normal_err_count", n_err, 0);
    check("normal_pops", n_pop, 320);
    check("normal_first_valid", t_first_pop - t_start, Samp + 1);
    check("normal_sb_empty", sb.size(), 0);

    // Mid-line resync at pixel 100
    n_pop = 0;
    n_d0 = n_done;
    for (int x = 0; x < 100; x++) sb.push_back({9'(x), 2'd3});
    do_sync();
    cycles(58 + 100 * 46);
    t_x = cyc;
    for (int x = 100; x < 109; x++) sb.push_back({9'(x), 2'd0});
    set_tone(1200);
    cycles(400);
    set_tone(2200);
    t_first = cyc;
    for (int x = 0; x < 5; x++) sb.push_back({9'(x), 2'd3});
    cycles(58 + 240);
    check("resync_err_count", n_err, 1);
    check("resync_err_lat", t_err - t_x, 400);
    check("resync_no_done", n_done - n_d0, 0);
    check("resync_start_lat", t_start - t_first, 58);
    check("resync_pops", n_pop, 114);
    check("resync_sb_empty", sb.size(), 0);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Backpressure for a whole line
    pix_ready = 1'b0;
    n_pop = 0;
    for (int x = 0; x < 4; x++) sb.push_back({9'(x), 2'd3});
    do_sync();
    cycles(58 + 4 * 46 + Samp);
    check("bp_ovf_before", overflow, 0);
    check("bp_valid", pix_valid, 1);
    check("bp_head_x", pix_x, 0);
    check("bp_head_data", pix_data, 3);
    cycles(1);
    check("bp_ovf_after", overflow, 1);
    wait_done(16000);
    check("bp_head_x_end", pix_x, 0);
    check("bp_head_data_end", pix_data, 3);
    check("bp_no_pops", n_pop, 0);
    pix_ready = 1'b1;
    cycles(8);
    check("bp_drained", n_pop, 4);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_valid_end", pix_valid, 0);
    check("bp_ovf_sticky", overflow, 1);

    // Asynchronous reset with three entries queued
    pix_ready = 1'b0;
    do_sync();
    cycles(58 + 2 * 46 + Samp + 2);
    check("arst_valid_before", pix_valid, 1);
    check("arst_ovf_before", overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", pix_valid, 0);
    check("arst_ovf", overflow, 0);
    check("arst_pix_x", pix_x, 0);
    sb.delete();
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Greyscale ramp, then one slot whose colour varies tick by tick
`ifdef SSTV_LINE_CAPTURE_AVG_EN
    mix_exp = 0;
    for (int t = 19; t <= 26; t++) mix_exp += t % 4;
    mix_exp = mix_exp >> 3;
`else
    mix_exp = 23 % 4;
`endif
    pix_ready = 1'b1;
    n_pop = 0;
    n_s0 = n_start;
    sb.push_back({9'd0, 2'd0});
    sb.push_back({9'd1, 2'd1});
    sb.push_back({9'd2, 2'd2});
    sb.push_back({9'd3, 2'd3});
    sb.push_back({9'd4, 2'(mix_exp)});
    do_sync();
    cycles(58);
    set_tone(1600);
    cycles(46);
    set_tone(1800);
    cycles(46);
    set_tone(2000);
    cycles(46);
    set_tone(2200);
    cycles(46);
    for (int t = 0; t < 46; t++) begin
      color = 2'(t % 4);
      cycles(1);
    end
    cycles(4);
    check("ramp_start_count", n_start - n_s0, 1);
    check("ramp_start_lat", t_start - t_first, 58);
    check("ramp_pops", n_pop, 5);
    check("ramp_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sstv_line_capture.md
# sstv_line_capture

Downstream consumer of the SSTV pixel colour decoder. Watches the instantaneous tone frequency for the 1200 Hz horizontal sync and times out pixel slots along each scanline. For each slot it samples the decoder's 2-bit greyscale colour and delivers `{pixel index, colour}` through a small FIFO with a valid/ready handshake. Sits between `sstv_pixel` and the frame-buffer writer.

## Interface

Parameters:
- `PIXELS_PER_LINE`, 320: pixels per scanline; must be ≤ 512.
- `PIXEL_TICKS`, 46: clock cycles per pixel slot; must be ≥ 8.
- `SYNC_TICKS_MIN`, 400: consecutive in-window cycles that qualify a sync pulse.
- `PORCH_TICKS`, 57: cycles from sync end to the first pixel slot.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two.

Ports:
- `clk` in 1: single clock (100 kHz nominal).
- `reset` in 1: asynchronous, active-high.
- `freq` in 12: tone frequency in Hz, same bus that feeds `sstv_pixel`.
- `color` in 2: colour from `sstv_pixel` for the current `freq`.
- `pix_ready` in 1: consumer accepts the head FIFO entry.
- `pix_valid` out 1: FIFO is non-empty.
- `pix_data` out 2: colour of the head entry.
- `pix_x` out 9: pixel index of the head entry.
- `line_start` out 1: one-cycle pulse on entry to ACTIVE.
- `line_done` out 1: one-cycle pulse at the end of the last slot.
- `line_err` out 1: one-cycle pulse when a sync interrupts ACTIVE.
- `overflow` out 1: sticky; set when a pixel is dropped because the FIFO is full.

## Operation

- Sync window: `in_sync` = (`freq` > 1100) && (`freq` ≤ 1300), evaluated as unsigned 12-bit.
- Sync counter:
  - increments while `in_sync`, saturating at `SYNC_TICKS_MIN`;
  - clears on any cycle where `in_sync` is low;
  - runs in every state.
- IDLE → SYNC when the counter reaches `SYNC_TICKS_MIN`.
- SYNC:
  - stays while `in_sync`;
  - on the first cycle with `in_sync` low → PORCH, porch counter cleared.
- PORCH:
  - counts `PORCH_TICKS` cycles, ignoring `freq`;
  - then → ACTIVE, pulsing `line_start`, with tick = 0 and pixel = 0.
- ACTIVE:
  - tick counts 0..`PIXEL_TICKS`-1, then wraps and increments pixel;
  - sample point: the cycle where tick == `PIXEL_TICKS`/2 (integer divide); `{pixel, colour}` is pushed into the FIFO.
  - At tick == `PIXEL_TICKS`-1 with pixel == `PIXELS_PER_LINE`-1: pulse `line_done`, go to IDLE.
- Sync during ACTIVE: if the sync counter reaches `SYNC_TICKS_MIN`, pulse `line_err`, go to SYNC and clear the pixel and tick counters. Pixels already queued remain in the FIFO.
- FIFO:
  - pop when `pix_valid` && `pix_ready`;
  - a push while full with no simultaneous pop drops the pixel and sets `overflow`;
  - a push and pop in the same cycle while full both succeed.
- Only `reset` clears `overflow`.
- Reset mid-line: the FIFO is flushed immediately and the FSM returns to IDLE.

## Timing

- Reset values:
  - state IDLE, all counters 0, FIFO empty;
  - `pix_valid`, `line_start`, `line_done`, `line_err` and `overflow` all 0;
  - `pix_data` = 0, `pix_x` = 0.
- Every output is registered.
- `pix_valid` rises on the cycle after a push into an empty FIFO, giving push-to-valid latency 1.
- `pix_data` and `pix_x` hold steady while `pix_valid` && !`pix_ready`.
- Sync qualification: SYNC is entered on the cycle after the `SYNC_TICKS_MIN`th consecutive in-window cycle.
- `line_start` is asserted `PORCH_TICKS`+1 cycles after the first out-of-window cycle in SYNC.
- With defaults, `line_done` comes `PIXELS_PER_LINE`×`PIXEL_TICKS` - 1 = 14719 cycles after `line_start`.

## Configuration

- `SSTV_LINE_CAPTURE_AVG_EN` defined (averaging mode):
  - the colour is summed over the 8 cycles with tick from `PIXEL_TICKS`/2 - 4 to `PIXEL_TICKS`/2 + 3, using a 5-bit sum;
  - pushed colour = sum >> 3;
  - the push happens on the last of those 8 cycles.
- Undefined: single-sample mode at tick == `PIXEL_TICKS`/2, as described in Operation.

## Test plan

- Normal line:
  - stimulus: `freq`=1200 for 400 cycles, then `freq`=2200 with `pix_ready`=1;
  - response: `line_start` 58 cycles after the first 2200 cycle, then 320 entries with `pix_x` 0..319 and all `pix_data`=3, then `line_done`, `line_err`=0.
- Short sync:
  - stimulus: `freq`=1200 for 399 cycles, then 1500;
  - response: state stays IDLE, with no `line_start`.
- Mid-line resync:
  - stimulus: during ACTIVE at pixel 100, `freq`=1200 for 400 cycles;
  - response: `line_err` pulses once, and after sync ends a new `line_start` restarts `pix_x` at 0.
- Backpressure:
  - stimulus: `pix_ready`=0 for a whole line;
  - response: the FIFO holds `pix_x` 0..3, `overflow`=1 from the 5th sample onward, and head data stays stable.
- Greyscale ramp:
  - stimulus: hold `freq` 1600/1800/2000/2200 across four consecutive slots;
  - response: `pix_data` = 0/1/2/3. Repeat with and without `SSTV_LINE_CAPTURE_AVG_EN`.
- Async reset:
  - stimulus: assert `reset` mid-line with 3 FIFO entries queued;
  - response: `pix_valid` and `overflow` go to 0 without a clock edge, and the next sync is acquired normally.
